// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch FSM with a circular instruction queue feeding decode
module fetch_queue #(
    parameter int          QUEUE_LOG = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clear_in,
    input  logic [31:0] clear_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_ins,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    input  logic        ins_pop
);

    localparam int DEPTH = 1 << QUEUE_LOG;

    // DISCARD waits out a response whose request was issued before a redirect
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [31:0]          pc;
    logic [QUEUE_LOG-1:0] head;
    logic [QUEUE_LOG-1:0] tail;
    logic [QUEUE_LOG:0]   count;
    logic [63:0]          entries [0:DEPTH-1];
    logic [63:0]          head_entry;
    logic                 full;
    logic                 issue;
    logic                 retire;
    logic                 push;
    logic                 pop;

    // count never exceeds DEPTH, so its top bit alone means "full"
    assign full       = count[QUEUE_LOG];
    assign ins_valid  = (count != '0);
    assign pop        = ins_valid & ins_pop & ~clear_in;
    assign head_entry = entries[head];
    assign ins_pc     = ins_valid ? head_entry[63:32] : 32'h0;
    assign ins_out    = ins_valid ? head_entry[31:0]  : 32'h0;

    // Next-state logic: one outstanding request, redirect turns a pending response stale
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        retire    = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!clear_in && !full) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    retire    = 1'b1;
                    push      = ~clear_in;
                    state_nxt = S_IDLE;
                end else if (clear_in) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_done) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory request: address captured at issue and held until the response arrives
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
        end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
        end else if (retire) begin
            mem_req  <= 1'b0;
        end
    end

    // Fetch PC: redirect wins, otherwise advance by one word per accepted response
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc <= RESET_PC;
        end else if (clear_in) begin
            pc <= clear_pc;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + QUEUE_LOG'(1);
            end
            if (pop) begin
                head <= head + QUEUE_LOG'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (QUEUE_LOG+1)'(1);
                2'b01:   count <= count - (QUEUE_LOG+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: {pc, word} written at the tail; contents need no reset
    always_ff @(posedge clk_in) begin
        if (push) begin
            entries[tail] <= {pc, mem_ins};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk_in;
    logic        rst_in;
    logic        clear_in;
    logic [31:0] clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_ins;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        ins_pop;

    int          checks;
    int          failures;

    logic        mem_auto;
    int          mem_lat;
    int          lat_cnt;
    logic        done_auto;
    logic [31:0] ins_auto;
    logic        man_done;
    logic [31:0] man_ins;

    assign mem_done = done_auto | man_done;
    assign mem_ins  = man_done ? man_ins : ins_auto;

    fetch_queue #(.QUEUE_LOG(4), .RESET_PC(32'h0)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (clear_in),
        .clear_pc  (clear_pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_done  (mem_done),
        .mem_ins   (mem_ins),
        .ins_valid (ins_valid),
        .ins_out   (ins_out),
        .ins_pc    (ins_pc),
        .ins_pop   (ins_pop)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory model: answers mem_req after mem_lat cycles with addr + 0x100
    initial begin
        done_auto = 1'b0;
        ins_auto  = 32'h0;
        lat_cnt   = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_in || !mem_auto) begin
                done_auto = 1'b0;
                lat_cnt   = 0;
            end else if (done_auto) begin
                done_auto = 1'b0;
                lat_cnt   = 0;
            end else if (mem_req) begin
                lat_cnt = lat_cnt + 1;
                if (lat_cnt >= mem_lat) begin
                    done_auto = 1'b1;
                    ins_auto  = mem_addr + 32'h100;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk_in);
    endtask

    task automatic do_reset;
        rst_in   = 1'b1;
        ins_pop  = 1'b0;
        clear_in = 1'b0;
        man_done = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_req req=%b addr=%h exp req=0 addr=0", mem_req, mem_addr);
        end
        checks++;
        if (ins_valid !== 1'b0 || ins_out !== 32'h0 || ins_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_out valid=%b out=%h pc=%h exp all 0", ins_valid, ins_out, ins_pc);
        end
        rst_in = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_req req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr);
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_async req=%b addr=%h exp req=0 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_fetch_order;
        int          n;
        logic [31:0] exp;
        mem_auto = 1'b1;
        mem_lat  = 3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = 32'(4 * i);
            n = 0;
            while (!mem_req && n < 20) begin tick(); n++; end
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp) begin
                failures++;
                $display("FAIL order_req%0d req=%b addr=%h exp req=1 addr=%h", i, mem_req, mem_addr, exp);
            end
            n = 0;
            while (!mem_done && n < 20) begin tick(); n++; end
            checks++;
            if (mem_done !== 1'b1 || ins_valid !== 1'b0) begin
                failures++;
                $display("FAIL order_nobypass%0d done=%b valid=%b exp done=1 valid=0", i, mem_done, ins_valid);
            end
            tick();
            checks++;
            if (ins_valid !== 1'b1 || ins_pc !== exp || ins_out !== exp + 32'h100 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL order_head%0d valid=%b pc=%h out=%h req=%b exp 1 %h %h 0",
                         i, ins_valid, ins_pc, ins_out, mem_req, exp, exp + 32'h100);
            end
            ins_pop = 1'b1;
            tick();
            ins_pop = 1'b0;
        end
        checks++;
        if (ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL order_empty valid=%b exp 0", ins_valid);
        end
    endtask

    task automatic test_full;
        int n;
        int dones;
        int bad_req;
        mem_auto = 1'b1;
        mem_lat  = 3;
        do_reset();
        dones = 0;
        n = 0;
        while (dones < 16 && n < 300) begin
            tick();
            n++;
            if (mem_done) dones++;
        end
        tick();
        bad_req = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) bad_req++;
            if (mem_done) dones++;
            tick();
        end
        checks++;
        if (dones !== 16) begin
            failures++;
            $display("FAIL full_pushes got=%0d exp=16", dones);
        end
        checks++;
        if (bad_req !== 0) begin
            failures++;
            $display("FAIL full_req_held cycles_with_req=%0d exp=0", bad_req);
        end
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || ins_out !== 32'h100) begin
            failures++;
            $display("FAIL full_head valid=%b pc=%h out=%h exp 1 0 100", ins_valid, ins_pc, ins_out);
        end
        ins_pop = 1'b1;
        tick();
        ins_pop = 1'b0;
        checks++;
        if (ins_pc !== 32'h4 || ins_out !== 32'h104 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL full_pop pc=%h out=%h req=%b exp 4 104 0", ins_pc, ins_out, mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL full_refetch req=%b addr=%h exp req=1 addr=40", mem_req, mem_addr);
        end
    endtask

    task automatic test_clear_pop;
        int n;
        int dones;
        mem_auto = 1'b1;
        mem_lat  = 3;
        do_reset();
        dones = 0;
        n = 0;
        while (dones < 3 && n < 100) begin
            tick();
            n++;
            if (mem_done) dones++;
        end
        tick();
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL clrpop_pre valid=%b pc=%h req=%b exp 1 0 0", ins_valid, ins_pc, mem_req);
        end
        clear_in = 1'b1;
        clear_pc = 32'h200;
        ins_pop  = 1'b1;
        tick();
        clear_in = 1'b0;
        ins_pop  = 1'b0;
        checks++;
        if (ins_valid !== 1'b0 || ins_pc !== 32'h0 || ins_out !== 32'h0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL clrpop_flush valid=%b pc=%h out=%h req=%b exp 0 0 0 0", ins_valid, ins_pc, ins_out, mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL clrpop_req req=%b addr=%h exp req=1 addr=200", mem_req, mem_addr);
        end
        n = 0;
        while (!mem_done && n < 20) begin tick(); n++; end
        tick();
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h200 || ins_out !== 32'h300) begin
            failures++;
            $display("FAIL clrpop_head valid=%b pc=%h out=%h exp 1 200 300", ins_valid, ins_pc, ins_out);
        end
    endtask

    task automatic test_clear_wait;
        mem_auto = 1'b0;
        do_reset();
        clear_in = 1'b1;
        clear_pc = 32'h10;
        tick();
        clear_in = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL clrwait_idle req=%b exp 0", mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL clrwait_req req=%b addr=%h exp req=1 addr=10", mem_req, mem_addr);
        end
        clear_in = 1'b1;
        clear_pc = 32'h300;
        tick();
        clear_pc = 32'h340;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL clrwait_stale req=%b addr=%h exp req=1 addr=10", mem_req, mem_addr);
        end
        tick();
        clear_in = 1'b0;
        man_done = 1'b1;
        man_ins  = 32'hDEAD0010;
        tick();
        man_done = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL clrwait_drop req=%b valid=%b exp 0 0", mem_req, ins_valid);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h340) begin
            failures++;
            $display("FAIL clrwait_redirect req=%b addr=%h exp req=1 addr=340", mem_req, mem_addr);
        end
        man_done = 1'b1;
        man_ins  = 32'h440;
        tick();
        man_done = 1'b0;
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h340 || ins_out !== 32'h440) begin
            failures++;
            $display("FAIL clrwait_head valid=%b pc=%h out=%h exp 1 340 440", ins_valid, ins_pc, ins_out);
        end
    endtask

    task automatic test_clear_done;
        mem_auto = 1'b0;
        do_reset();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL clrdone_req req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr);
        end
        tick();
        clear_in = 1'b1;
        clear_pc = 32'h500;
        man_done = 1'b1;
        man_ins  = 32'h00000BAD;
        tick();
        clear_in = 1'b0;
        man_done = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL clrdone_drop req=%b valid=%b exp 0 0", mem_req, ins_valid);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            failures++;
            $display("FAIL clrdone_redirect req=%b addr=%h exp req=1 addr=500", mem_req, mem_addr);
        end
        man_done = 1'b1;
        man_ins  = 32'h600;
        tick();
        man_done = 1'b0;
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h500 || ins_out !== 32'h600) begin
            failures++;
            $display("FAIL clrdone_head valid=%b pc=%h out=%h exp 1 500 600", ins_valid, ins_pc, ins_out);
        end
    endtask

    task automatic test_back_to_back;
        int          n;
        int          dones;
        int          paired;
        logic [31:0] exp_head;
        mem_auto = 1'b1;
        mem_lat  = 1;
        do_reset();
        dones    = 0;
        paired   = 0;
        exp_head = 32'h0;
        n = 0;
        while (paired < 20 && n < 400) begin
            tick();
            n++;
            ins_pop = 1'b0;
            if (mem_done) begin
                if (dones >= 15) begin
                    checks++;
                    if (ins_valid !== 1'b1 || ins_pc !== exp_head || ins_out !== exp_head + 32'h100) begin
                        failures++;
                        $display("FAIL b2b_pair%0d valid=%b pc=%h out=%h exp 1 %h %h",
                                 paired, ins_valid, ins_pc, ins_out, exp_head, exp_head + 32'h100);
                    end
                    ins_pop  = 1'b1;
                    exp_head = exp_head + 32'h4;
                    paired++;
                end
                dones++;
            end
        end
        tick();
        ins_pop  = 1'b0;
        mem_auto = 1'b0;
        checks++;
        if (paired !== 20) begin
            failures++;
            $display("FAIL b2b_pairs got=%0d exp=20", paired);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_pc !== exp_head || ins_out !== exp_head + 32'h100) begin
                failures++;
                $display("FAIL b2b_drain%0d valid=%b pc=%h out=%h exp 1 %h %h",
                         i, ins_valid, ins_pc, ins_out, exp_head, exp_head + 32'h100);
            end
            ins_pop  = 1'b1;
            exp_head = exp_head + 32'h4;
            tick();
        end
        ins_pop = 1'b0;
        checks++;
        if (ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty valid=%b exp 0", ins_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_in   = 1'b1;
        clear_in = 1'b0;
        clear_pc = 32'h0;
        ins_pop  = 1'b0;
        man_done = 1'b0;
        man_ins  = 32'h0;
        mem_auto = 1'b1;
        mem_lat  = 3;
        test_reset();
        test_fetch_order();
        test_full();
        test_clear_pop();
        test_clear_wait();
        test_clear_done();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
